// File: rtl/sargantana_icache_valid_ctrl.sv
// -----------------------------------------------------------------------------
// sargantana_icache_valid_ctrl
//
// Controller for the instruction-cache valid-bit RAM. It arbitrates single-port
// access among refill (set one way's valid bit), invalidate (clear all ways at
// one index) and lookup (read all ways at one index). It also runs a full-cache
// flush walk that clears every set, one index per cycle.
//
// Ports
//   clk_i, rstn_i            clock; asynchronous active-low reset
//   flush_req_i              start (or queue) a full valid-bit clear
//   refill_req_i/_idx_i/_way_i   set the valid bit of one way at an index
//   inval_req_i/_idx_i       clear the valid bits of all ways at an index
//   lookup_req_i/_idx_i      read the valid bits of all ways at an index
//   refill/inval/lookup_gnt_o    request served this cycle (combinational)
//   vram_req_o/_we_o/_addr_o/_wdata_o  valid-bit RAM port (per-way enables)
//   flush_busy_o             walk or completion cycle in progress
//   flush_done_o             one-cycle pulse when a walk completes
// -----------------------------------------------------------------------------
module sargantana_icache_valid_ctrl #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            flush_req_i,
    input  logic                            refill_req_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     refill_idx_i,
    input  logic [$clog2(ICACHE_N_WAY)-1:0] refill_way_i,
    input  logic                            inval_req_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     inval_idx_i,
    input  logic                            lookup_req_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]     lookup_idx_i,
    output logic                            refill_gnt_o,
    output logic                            inval_gnt_o,
    output logic                            lookup_gnt_o,
    output logic [ICACHE_N_WAY-1:0]         vram_req_o,
    output logic                            vram_we_o,
    output logic [ICACHE_IDX_WIDTH-1:0]     vram_addr_o,
    output logic                            vram_wdata_o,
    output logic                            flush_busy_o,
    output logic                            flush_done_o
);

    // The last set index is all ones because NSETS is a power of two.
    localparam logic [ICACHE_IDX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q, cnt_d;       // flush walk address
    logic                        pend_q, pend_d;     // flush requested during a walk
    logic [1:0]                  starve_q, starve_d; // lookup starvation guard

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        starve_d     = starve_q;
        refill_gnt_o = 1'b0;
        inval_gnt_o  = 1'b0;
        lookup_gnt_o = 1'b0;
        vram_req_o   = '0;
        vram_we_o    = 1'b0;
        vram_addr_o  = '0;
        vram_wdata_o = 1'b0;
        flush_busy_o = 1'b0;
        flush_done_o = 1'b0;

        if (!lookup_req_i) begin
            starve_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (flush_req_i || pend_q) begin
                    // Flush wins over every requester; this cycle is silent.
                    state_d = FLUSH;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (lookup_req_i && starve_q == 2'd3) begin
                    lookup_gnt_o = 1'b1;
                end else if (refill_req_i) begin
                    refill_gnt_o = 1'b1;
                end else if (inval_req_i) begin
                    inval_gnt_o = 1'b1;
                end else if (lookup_req_i) begin
                    lookup_gnt_o = 1'b1;
                end

                if (refill_gnt_o) begin
                    vram_req_o[refill_way_i] = 1'b1;
                    vram_we_o    = 1'b1;
                    vram_wdata_o = 1'b1;
                    vram_addr_o  = refill_idx_i;
                end else if (inval_gnt_o) begin
                    vram_req_o  = '1;
                    vram_we_o   = 1'b1;
                    vram_addr_o = inval_idx_i;
                end else if (lookup_gnt_o) begin
                    vram_req_o  = '1;
                    vram_addr_o = lookup_idx_i;
                end

                // Saturate at 3 so a flush start on that cycle cannot wrap it.
                if (lookup_req_i) begin
                    if (lookup_gnt_o) begin
                        starve_d = 2'd0;
                    end else if (starve_q != 2'd3) begin
                        starve_d = starve_q + 2'd1;
                    end
                end
            end

            FLUSH: begin
                flush_busy_o = 1'b1;
                vram_req_o   = '1;
                vram_we_o    = 1'b1;
                vram_addr_o  = cnt_q;
                if (flush_req_i) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                flush_busy_o = 1'b1;
                flush_done_o = 1'b1;
                if (flush_req_i) begin
                    pend_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Outputs follow reset immediately rather than waiting for a clock.
        if (!rstn_i) begin
            refill_gnt_o = 1'b0;
            inval_gnt_o  = 1'b0;
            lookup_gnt_o = 1'b0;
            vram_req_o   = '0;
            vram_we_o    = 1'b0;
            vram_addr_o  = '0;
            vram_wdata_o = 1'b0;
            flush_busy_o = 1'b0;
            flush_done_o = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            starve_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_sargantana_icache_valid_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sargantana_icache_valid_ctrl
//
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the flush walk, the pending flush, the fixed
// priority and the lookup starvation guard.
// -----------------------------------------------------------------------------
module tb_sargantana_icache_valid_ctrl;

    localparam int N_WAY = 4;
    localparam int IW    = 6;
    localparam int NSETS = 1 << IW;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          flush_req_i, refill_req_i, inval_req_i, lookup_req_i;
    logic [IW-1:0] refill_idx_i, inval_idx_i, lookup_idx_i;
    logic [1:0]    refill_way_i;
    logic          refill_gnt_o, inval_gnt_o, lookup_gnt_o;
    logic [3:0]    vram_req_o;
    logic          vram_we_o, vram_wdata_o, flush_busy_o, flush_done_o;
    logic [IW-1:0] vram_addr_o;

    int checks   = 0;
    int failures = 0;

    // Model state: m_walk = -1 idle, 0..NSETS-1 next address written, NSETS = done cycle.
    int m_walk   = -1;
    bit m_pend   = 0;
    int m_starve = 0;

    sargantana_icache_valid_ctrl #(
        .ICACHE_N_WAY    (N_WAY),
        .ICACHE_IDX_WIDTH(IW)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_req_i  (flush_req_i),
        .refill_req_i (refill_req_i),
        .refill_idx_i (refill_idx_i),
        .refill_way_i (refill_way_i),
        .inval_req_i  (inval_req_i),
        .inval_idx_i  (inval_idx_i),
        .lookup_req_i (lookup_req_i),
        .lookup_idx_i (lookup_idx_i),
        .refill_gnt_o (refill_gnt_o),
        .inval_gnt_o  (inval_gnt_o),
        .lookup_gnt_o (lookup_gnt_o),
        .vram_req_o   (vram_req_o),
        .vram_we_o    (vram_we_o),
        .vram_addr_o  (vram_addr_o),
        .vram_wdata_o (vram_wdata_o),
        .flush_busy_o (flush_busy_o),
        .flush_done_o (flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Bit layout: rg[16] ig[15] lg[14] req[13:10] we[9] addr[8:3] wdata[2] busy[1] done[0]
    function automatic logic [16:0] obs_vec();
        return {refill_gnt_o, inval_gnt_o, lookup_gnt_o, vram_req_o, vram_we_o,
                vram_addr_o, vram_wdata_o, flush_busy_o, flush_done_o};
    endfunction

    function automatic logic [16:0] model_out();
        logic rg = 0, ig = 0, lg = 0, we = 0, wd = 0, busy = 0, done = 0;
        logic [3:0]    rq = 0;
        logic [IW-1:0] ad = 0;
        if (rstn_i === 1'b1) begin
            if (m_walk >= 0 && m_walk < NSETS) begin
                rq = 4'hF; we = 1; ad = m_walk[IW-1:0]; busy = 1;
            end else if (m_walk == NSETS) begin
                busy = 1; done = 1;
            end else if (!(flush_req_i || m_pend)) begin
                if (lookup_req_i && m_starve == 3) lg = 1;
                else if (refill_req_i)             rg = 1;
                else if (inval_req_i)              ig = 1;
                else if (lookup_req_i)             lg = 1;
                if (rg) begin
                    rq = 4'b0001 << refill_way_i; we = 1; wd = 1; ad = refill_idx_i;
                end else if (ig) begin
                    rq = 4'hF; we = 1; ad = inval_idx_i;
                end else if (lg) begin
                    rq = 4'hF; ad = lookup_idx_i;
                end
            end
        end
        return {rg, ig, lg, rq, we, ad, wd, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_walk = -1; m_pend = 0; m_starve = 0;
    endtask

    // Model transition on a rising edge, using the inputs held across it.
    task automatic model_edge();
        logic [16:0] e;
        e = model_out();
        if (m_walk < 0) begin
            if (flush_req_i || m_pend) begin
                m_walk = 0; m_pend = 0;
            end
            if (!lookup_req_i || e[14]) m_starve = 0;
            else if (m_starve < 3)      m_starve++;
        end else begin
            if (flush_req_i) m_pend = 1;
            if (!lookup_req_i) m_starve = 0;
            m_walk = (m_walk == NSETS) ? -1 : m_walk + 1;
        end
    endtask

    task automatic settle_check(input string tag);
        #2;
        check(tag, {15'd0, obs_vec()}, {15'd0, model_out()});
    endtask

    task automatic clk_step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic tick(input string tag);
        settle_check(tag);
        clk_step();
    endtask

    task automatic clear_inputs();
        flush_req_i = 0; refill_req_i = 0; inval_req_i = 0; lookup_req_i = 0;
        refill_idx_i = 0; inval_idx_i = 0; lookup_idx_i = 0; refill_way_i = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        rstn_i = 0;
        #1;
        model_reset();
        check({tag, "_zero"}, {15'd0, obs_vec()}, 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1;
    endtask

    initial begin
        int done_at [$];
        int busy_n, wr_n, act_n;

        clear_inputs();
        rstn_i = 0;
        refill_req_i = 1; lookup_req_i = 1; flush_req_i = 1;
        #2;
        check("reset_outputs", {15'd0, obs_vec()}, 32'd0);
        clear_inputs();
        @(posedge clk_i);
        #1;
        rstn_i = 1;
        tick("idle_after_reset");

        // Priority: all three, then refill dropped, then inval dropped.
        refill_req_i = 1; inval_req_i = 1; lookup_req_i = 1;
        refill_idx_i = 6'd7; inval_idx_i = 6'd9; lookup_idx_i = 6'd11; refill_way_i = 2'd1;
        settle_check("prio_all");
        check("prio_all_gnt", {29'd0, refill_gnt_o, inval_gnt_o, lookup_gnt_o}, 32'b100);
        clk_step();
        refill_req_i = 0;
        settle_check("prio_inval");
        check("prio_inval_gnt", {29'd0, refill_gnt_o, inval_gnt_o, lookup_gnt_o}, 32'b010);
        clk_step();
        inval_req_i = 0;
        settle_check("prio_lookup");
        check("prio_lookup_gnt", {29'd0, refill_gnt_o, inval_gnt_o, lookup_gnt_o}, 32'b001);
        clk_step();
        clear_inputs();
        tick("quiet");

        // Refill way 2, index 5.
        refill_req_i = 1; refill_way_i = 2'd2; refill_idx_i = 6'd5;
        settle_check("refill_way2");
        check("refill_way2_port", {20'd0, vram_req_o, vram_we_o, vram_wdata_o, vram_addr_o},
              {20'd0, 4'b0100, 1'b1, 1'b1, 6'd5});
        clk_step();
        clear_inputs();
        tick("quiet2");

        // Starvation guard: lookup granted on the 4th cycle, then refill resumes.
        lookup_req_i = 1; refill_req_i = 1; refill_idx_i = 6'd3; lookup_idx_i = 6'd44;
        for (int c = 1; c <= 6; c++) begin
            settle_check("starve");
            check($sformatf("starve_lgnt_c%0d", c), {31'd0, lookup_gnt_o},
                  (c == 4) ? 32'd1 : 32'd0);
            clk_step();
        end
        clear_inputs();
        tick("quiet3");

        // Single flush walk, counted from the start cycle.
        busy_n = 0; wr_n = 0; done_at.delete();
        flush_req_i = 1;
        for (int c = 0; c <= 70; c++) begin
            settle_check("walk1");
            if (flush_busy_o === 1'b1) busy_n++;
            if (vram_req_o === 4'hF && vram_we_o === 1'b1 && vram_wdata_o === 1'b0) wr_n++;
            if (flush_done_o === 1'b1) done_at.push_back(c);
            if (c == 1)  check("walk1_first_addr", {26'd0, vram_addr_o}, 32'd0);
            if (c == 64) check("walk1_last_addr", {26'd0, vram_addr_o}, 32'd63);
            clk_step();
            flush_req_i = 0;
        end
        check("walk1_busy_cycles", busy_n, 32'd65);
        check("walk1_writes", wr_n, 32'd64);
        check("walk1_done_count", done_at.size(), 32'd1);
        if (done_at.size() > 0) check("walk1_done_cycle", done_at[0], 32'd65);

        // Flush re-requested at walk cycle 10 queues a second walk.
        done_at.delete(); wr_n = 0;
        flush_req_i = 1;
        for (int c = 0; c <= 140; c++) begin
            if (c == 10) flush_req_i = 1;
            settle_check("walk2");
            if (flush_done_o === 1'b1) done_at.push_back(c);
            if (c == 66) check("walk2_restart_silent", {28'd0, vram_req_o}, 32'd0);
            if (vram_we_o === 1'b1) wr_n++;
            clk_step();
            flush_req_i = 0;
        end
        check("walk2_done_count", done_at.size(), 32'd2);
        if (done_at.size() == 2) check("walk2_second_done", done_at[1], 32'd131);
        check("walk2_writes", wr_n, 32'd128);

        // Reset at walk cycle 20 aborts the walk; nothing resumes afterwards.
        flush_req_i = 1;
        tick("walk3_start");
        flush_req_i = 0;
        for (int c = 1; c < 20; c++) tick("walk3");
        #2;
        check("walk3_busy_before_rst", {31'd0, flush_busy_o}, 32'd1);
        async_reset("walk3_rst");
        act_n = 0; done_at.delete();
        for (int c = 0; c < 80; c++) begin
            settle_check("after_rst");
            if (vram_req_o !== 4'd0) act_n++;
            if (flush_done_o === 1'b1) done_at.push_back(c);
            clk_step();
        end
        check("after_rst_activity", act_n, 32'd0);
        check("after_rst_done", done_at.size(), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            flush_req_i  = ($urandom_range(0, 199) == 0);
            refill_req_i = ($urandom_range(0, 2) == 0);
            inval_req_i  = ($urandom_range(0, 3) == 0);
            lookup_req_i = ($urandom_range(0, 1) == 0);
            refill_idx_i = IW'($urandom);
            inval_idx_i  = IW'($urandom);
            lookup_idx_i = IW'($urandom);
            refill_way_i = 2'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rand_rst");
            end else begin
                tick("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_valid_ctrl.md
SARGANTANA_ICACHE_VALID_CTRL -- requirements
Module: sargantana_icache_valid_ctrl

Interface
REQ-001 SHALL have parameter ICACHE_N_WAY, default 4, number of ways (power of 2, >=2).
REQ-002 SHALL have parameter ICACHE_IDX_WIDTH, default 6, set-index width; NSETS = 2**ICACHE_IDX_WIDTH.
REQ-003 SHALL have clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have flush_req_i  in  1  request full-cache valid-bit clear (level or pulse).
REQ-006 SHALL have refill_req_i  in  1, refill_idx_i  in  ICACHE_IDX_WIDTH, refill_way_i  in  clog2(ICACHE_N_WAY): set valid bit of one way.
REQ-007 SHALL have inval_req_i  in  1, inval_idx_i  in  ICACHE_IDX_WIDTH: clear valid bits of all ways at one index.
REQ-008 SHALL have lookup_req_i  in  1, lookup_idx_i  in  ICACHE_IDX_WIDTH: read valid bits of all ways.
REQ-009 SHALL have refill_gnt_o, inval_gnt_o, lookup_gnt_o  out  1 each: request served this cycle.
REQ-010 SHALL have vram_req_o  out  ICACHE_N_WAY, vram_we_o  out  1, vram_addr_o  out  ICACHE_IDX_WIDTH, vram_wdata_o  out  1: valid-bit RAM port.
REQ-011 SHALL have flush_busy_o  out  1 (walk in progress) and flush_done_o  out  1 (one-cycle completion pulse).

Function
REQ-012 FSM states SHALL be IDLE, FLUSH, DONE; encoding free.
REQ-013 IDLE->FLUSH when flush_req_i=1 or flush_pend=1; counter loaded with 0 on that edge.
REQ-014 In FLUSH, each cycle SHALL drive vram_req_o='1, vram_we_o=1, vram_wdata_o=0, vram_addr_o=counter; counter increments by 1.
REQ-015 FLUSH->DONE on the cycle counter=NSETS-1 is issued; walk occupies exactly NSETS cycles; counter never wraps past NSETS-1.
REQ-016 DONE SHALL last one cycle with flush_done_o=1, no RAM access, then go to IDLE.
REQ-017 flush_busy_o=1 in FLUSH and DONE, else 0.
REQ-018 flush_req_i=1 sampled in FLUSH or DONE SHALL set flush_pend; flush_pend cleared on IDLE->FLUSH; pending flush starts the cycle after DONE.
REQ-019 In FLUSH and DONE all *_gnt_o SHALL be 0; requesters hold requests until granted.
REQ-020 In IDLE with no flush start, fixed priority refill > inval > lookup; at most one grant per cycle; grant combinational, same cycle as request.
REQ-021 The IDLE cycle on which a flush starts SHALL grant nothing and issue no RAM access (flush wins over all).
REQ-022 Refill grant: vram_req_o=one-hot(refill_way_i), vram_we_o=1, vram_wdata_o=1, vram_addr_o=refill_idx_i.
REQ-023 Inval grant: vram_req_o='1, vram_we_o=1, vram_wdata_o=0, vram_addr_o=inval_idx_i.
REQ-024 Lookup grant: vram_req_o='1, vram_we_o=0, vram_wdata_o=0, vram_addr_o=lookup_idx_i.
REQ-025 No grant: vram_req_o=0, vram_we_o=0, vram_wdata_o=0, vram_addr_o=0.
REQ-026 Lookup starvation guard: 2-bit counter increments each IDLE cycle lookup_req_i=1 and not granted; at value 3 lookup SHALL take top priority for one cycle; counter clears on lookup grant or when lookup_req_i=0.
REQ-027 Outputs SHALL be free of X when inputs are known; way index out of range not possible by width.

Reset
REQ-028 While rstn_i=0: state=IDLE, counter=0, flush_pend=0, starvation counter=0; all outputs 0 immediately (asynchronous).
REQ-029 Reset asserted mid-FLUSH SHALL abort the walk without flush_done_o; no auto-restart after deassertion unless flush_req_i=1.
REQ-030 First rising edge after rstn_i deassertion SHALL be a normal IDLE cycle.

Verification
REQ-031 Flush, IDX_WIDTH=6: flush_req_i pulse -> 64 consecutive writes addr 0..63, req='1, wdata=0; flush_done_o at cycle 65 after start; busy 65 cycles.
REQ-032 refill, inval, lookup all asserted in IDLE -> refill_gnt_o=1 only; with refill dropped -> inval_gnt_o=1; then lookup_gnt_o=1.
REQ-033 refill_req_i held with refill_way_i=2, idx=5 (N_WAY=4) -> vram_req_o=4'b0100, we=1, wdata=1, addr=5.
REQ-034 flush_req_i pulsed at walk cycle 10 -> second full 64-cycle walk begins cycle after first flush_done_o.
REQ-035 lookup_req_i and refill_req_i held continuously -> lookup granted on 4th cycle, then refill resumes.
REQ-036 rstn_i low at walk cycle 20 -> all outputs 0 same cycle; after release, no flush_done_o and no RAM activity with no requests.
